// File: rtl/pulpino_boot_ctrl.sv
// pulpino_boot_ctrl
//
// Sequences the core reset of a PULPino-style SoC. Core reset is held
// while any reset request is active and for a fixed time afterwards. It
// is then released, and instruction fetch is enabled a fixed time after
// that. A request can come from the debounced push button, from the
// debug master, or from the optional watchdog.
//
// Ports
//   clk_clk        system clock, everything runs on its rising edge
//   reset_reset_n  synchronous active-low block reset
//   key_n          raw push button, low = pressed (asynchronous)
//   jtag_reset     reset request from the debug master, high = request
//   boot_sel       boot address select switch (asynchronous)
//   wdt_kick       single-cycle watchdog refresh pulse
//   core_reset_n   core reset, low = core held in reset
//   fetch_enable   core instruction fetch enable
//   boot_addr      boot address latched when core reset is released
//   reset_count    completed reset sequences, saturates at 255
//   wdt_fired      sticky flag, set when the watchdog caused a reset
//
// Build option
//   BOOT_CTRL_WATCHDOG_EN  when defined, adds a watchdog that requests a
//                          reset after WDT_CYCLES cycles in RUN without a
//                          kick. When undefined, wdt_kick is ignored and
//                          wdt_fired is tied low.

module pulpino_boot_ctrl #(
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned FETCH_DELAY     = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic [31:0] BOOT_ADDR_0     = 32'h0000_8000,
    parameter logic [31:0] BOOT_ADDR_1     = 32'h0000_0000,
    parameter int unsigned WDT_CYCLES      = 50000000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        key_n,
    input  logic        jtag_reset,
    input  logic        boot_sel,
    input  logic        wdt_kick,
    output logic        core_reset_n,
    output logic        fetch_enable,
    output logic [31:0] boot_addr,
    output logic [7:0]  reset_count,
    output logic        wdt_fired
);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_e;

    // Terminal counts are "last index" values so the counters only ever
    // need to reach N-1.
    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] FETCH_LAST = 16'(FETCH_DELAY - 1);
    localparam int unsigned DEB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    state_e            state_q;
    logic [15:0]       cnt_q;
    logic              coreResetN_q;
    logic              fetchEnable_q;
    logic [31:0]       bootAddr_q;
    logic [7:0]        resetCount_q;

    logic              keySync1_q, keySync2_q;
    logic              bootSelSync1_q, bootSelSync2_q;
    logic              keyDeb_q, keyDeb_d;
    logic [DEB_W-1:0]  debCnt_q, debCnt_d;

    logic              wdtExpire;
    logic              req;

    // Two-flop synchronizers for the asynchronous button and switch.
    // They come out of reset showing "button released" and "select 0".
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            keySync1_q     <= 1'b1;
            keySync2_q     <= 1'b1;
            bootSelSync1_q <= 1'b0;
            bootSelSync2_q <= 1'b0;
        end else begin
            keySync1_q     <= key_n;
            keySync2_q     <= keySync1_q;
            bootSelSync1_q <= boot_sel;
            bootSelSync2_q <= bootSelSync1_q;
        end
    end

    // Debounce: count consecutive cycles where the synchronized key
    // disagrees with the accepted level. Any agreeing cycle restarts the
    // count; the level flips on the DEBOUNCE_CYCLES-th disagreeing cycle.
    always_comb begin
        keyDeb_d = keyDeb_q;
        debCnt_d = '0;
        if (keySync2_q != keyDeb_q) begin
            if (debCnt_q == DEB_LAST) begin
                keyDeb_d = keySync2_q;
            end else begin
                debCnt_d = debCnt_q + DEB_W'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            keyDeb_q <= 1'b1;
            debCnt_q <= '0;
        end else begin
            keyDeb_q <= keyDeb_d;
            debCnt_q <= debCnt_d;
        end
    end

`ifdef BOOT_CTRL_WATCHDOG_EN
    localparam int unsigned WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdtCnt_q, wdtCnt_d;
    logic             wdtFired_q;

    // The watchdog only ages while the core is running. A kick, the
    // expiry itself, or any time outside RUN returns it to zero, so every
    // stay in RUN starts with a fresh timeout. Expiry is a one-cycle
    // request because the FSM leaves RUN on the following edge.
    assign wdtExpire = (state_q == RUN) && !wdt_kick && (wdtCnt_q == WDT_LAST);

    always_comb begin
        wdtCnt_d = '0;
        if ((state_q == RUN) && !wdt_kick && !wdtExpire) begin
            wdtCnt_d = wdtCnt_q + WDT_W'(1);
        end
    end

    // Watchdog counter and the sticky flag that only block reset clears.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            wdtCnt_q   <= '0;
            wdtFired_q <= 1'b0;
        end else begin
            wdtCnt_q   <= wdtCnt_d;
            wdtFired_q <= wdtFired_q | wdtExpire;
        end
    end

    assign wdt_fired = wdtFired_q;
`else
    logic unusedWdtKick;

    assign unusedWdtKick = wdt_kick;
    assign wdtExpire     = 1'b0;
    assign wdt_fired     = 1'b0;
`endif

    assign req = ~keyDeb_q | jtag_reset | wdtExpire;

    // Reset sequencer. cnt_q counts request-free cycles in HOLD and then
    // cycles in RELEASE. Outputs are registered here, so they move on the
    // same edge as the state. The boot address is sampled only on the
    // HOLD->RELEASE edge so the switch cannot move the core under its feet.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q       <= HOLD;
            cnt_q         <= '0;
            coreResetN_q  <= 1'b0;
            fetchEnable_q <= 1'b0;
            bootAddr_q    <= BOOT_ADDR_0;
            resetCount_q  <= '0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (req) begin
                        cnt_q <= '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_q      <= RELEASE;
                        cnt_q        <= '0;
                        coreResetN_q <= 1'b1;
                        bootAddr_q   <= bootSelSync2_q ? BOOT_ADDR_1 : BOOT_ADDR_0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RELEASE: begin
                    if (req) begin
                        state_q      <= HOLD;
                        cnt_q        <= '0;
                        coreResetN_q <= 1'b0;
                    end else if (cnt_q == FETCH_LAST) begin
                        state_q       <= RUN;
                        cnt_q         <= '0;
                        fetchEnable_q <= 1'b1;
                        if (resetCount_q != 8'hFF) begin
                            resetCount_q <= resetCount_q + 8'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RUN: begin
                    if (req) begin
                        state_q       <= HOLD;
                        cnt_q         <= '0;
                        coreResetN_q  <= 1'b0;
                        fetchEnable_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= HOLD;
                    cnt_q         <= '0;
                    coreResetN_q  <= 1'b0;
                    fetchEnable_q <= 1'b0;
                end
            endcase
        end
    end

    assign core_reset_n = coreResetN_q;
    assign fetch_enable = fetchEnable_q;
    assign boot_addr    = bootAddr_q;
    assign reset_count  = resetCount_q;

endmodule

// File: tb/tb_pulpino_boot_ctrl.sv
// Testbench for pulpino_boot_ctrl. A reference model describes the
// controller in terms of "cycles since the last reset request": core reset
// is released once HOLD_CYCLES request-free cycles have elapsed and fetch
// is enabled after HOLD_CYCLES+FETCH_DELAY. The DUT is compared with the
// model on every cycle, and with hand-written expectations at the end of
// each table segment and hand-written sequence.

module tb_pulpino_boot_ctrl;

    localparam int HOLD  = 16;
    localparam int FETCH = 8;
    localparam int DEB   = 20;
    localparam int WDT   = 100;
    localparam logic [31:0] BA0 = 32'h0000_8000;
    localparam logic [31:0] BA1 = 32'h0000_0000;
`ifdef BOOT_CTRL_WATCHDOG_EN
    localparam bit WDT_EN = 1'b1;
`else
    localparam bit WDT_EN = 1'b0;
`endif

    logic        clk  = 1'b0;
    logic        rstN = 1'b0;
    logic        keyN = 1'b1;
    logic        jtag = 1'b0;
    logic        bsel = 1'b0;
    logic        kick = 1'b0;
    logic        coreResetN;
    logic        fetchEnable;
    logic [31:0] bootAddr;
    logic [7:0]  resetCount;
    logic        wdtFired;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int          mQuiet   = 0;
    bit          mKs1     = 1'b1;
    bit          mKs2     = 1'b1;
    bit          mKeyLvl  = 1'b1;
    bit          mLastS2  = 1'b1;
    int          mRun     = 0;
    bit          mBs1     = 1'b0;
    bit          mBs2     = 1'b0;
    int          mAge     = 0;
    logic [31:0] mAddr    = BA0;
    int          mCount   = 0;
    bit          mFired   = 1'b0;

    typedef struct {
        bit          rN;
        bit          k;
        bit          j;
        bit          b;
        int          cycles;
        bit          eCore;
        bit          eFetch;
        logic [31:0] eAddr;
        int          eCnt;
    } vec_t;

    vec_t vecs[28];

    pulpino_boot_ctrl #(
        .HOLD_CYCLES    (HOLD),
        .FETCH_DELAY    (FETCH),
        .DEBOUNCE_CYCLES(DEB),
        .BOOT_ADDR_0    (BA0),
        .BOOT_ADDR_1    (BA1),
        .WDT_CYCLES     (WDT)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rstN),
        .key_n        (keyN),
        .jtag_reset   (jtag),
        .boot_sel     (bsel),
        .wdt_kick     (kick),
        .core_reset_n (coreResetN),
        .fetch_enable (fetchEnable),
        .boot_addr    (bootAddr),
        .reset_count  (resetCount),
        .wdt_fired    (wdtFired)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    function automatic vec_t mk(bit rN, bit k, bit j, bit b, int n,
                                bit eCore, bit eFetch, logic [31:0] eAddr, int eCnt);
        vec_t v;
        v.rN = rN; v.k = k; v.j = j; v.b = b; v.cycles = n;
        v.eCore = eCore; v.eFetch = eFetch; v.eAddr = eAddr; v.eCnt = eCnt;
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic modelStep();
        bit inRun, expire, req;
        if (!rstN) begin
            mQuiet = 0; mKs1 = 1'b1; mKs2 = 1'b1; mKeyLvl = 1'b1; mLastS2 = 1'b1;
            mRun = 0; mBs1 = 1'b0; mBs2 = 1'b0; mAge = 0; mAddr = BA0;
            mCount = 0; mFired = 1'b0;
        end else begin
            inRun  = (mQuiet >= HOLD + FETCH);
            expire = WDT_EN && inRun && !kick && (mAge == WDT - 1);
            req    = !mKeyLvl || jtag || expire;
            mAge   = (inRun && !req && !kick) ? mAge + 1 : 0;
            if (expire) mFired = 1'b1;
            mQuiet = req ? 0 : mQuiet + 1;
            if (!req && mQuiet == HOLD) mAddr = mBs2 ? BA1 : BA0;
            if (!req && mQuiet == HOLD + FETCH && mCount < 255) mCount++;
            // accepted key level follows a run of DEB identical synced samples
            mRun    = (mKs2 == mLastS2) ? mRun + 1 : 1;
            mLastS2 = mKs2;
            if (mKs2 != mKeyLvl && mRun >= DEB) mKeyLvl = mKs2;
            mKs2 = mKs1; mKs1 = keyN;
            mBs2 = mBs1; mBs1 = bsel;
        end
    endtask

    task automatic checkOutput(input string name);
        logic [42:0] act, exp;
        act = {coreResetN, fetchEnable, bootAddr, resetCount, wdtFired};
        exp = {(mQuiet >= HOLD), (mQuiet >= HOLD + FETCH), mAddr, 8'(mCount), mFired};
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s @%0t: got core=%b fetch=%b addr=%h cnt=%0d wdt=%b, expected core=%b fetch=%b addr=%h cnt=%0d wdt=%b",
                     name, $time, act[42], act[41], act[40:9], act[8:1], act[0],
                     exp[42], exp[41], exp[40:9], exp[8:1], exp[0]);
        end
    endtask

    task automatic expectOut(input string name, input bit eCore, input bit eFetch,
                             input logic [31:0] eAddr, input int eCnt, input bit eFired);
        compared++;
        if (coreResetN !== eCore || fetchEnable !== eFetch || bootAddr !== eAddr ||
            resetCount !== 8'(eCnt) || wdtFired !== eFired) begin
            mismatched++;
            $display("[TB] FAIL %s @%0t: got core=%b fetch=%b addr=%h cnt=%0d wdt=%b, expected core=%b fetch=%b addr=%h cnt=%0d wdt=%b",
                     name, $time, coreResetN, fetchEnable, bootAddr, resetCount, wdtFired,
                     eCore, eFetch, eAddr, eCnt, eFired);
        end
    endtask

    // Drive inputs for n cycles, stepping the model and checking each cycle.
    task automatic applyStimulus(input bit r, input bit k, input bit j,
                                 input bit b, input bit w, input int n);
        for (int i = 0; i < n; i++) begin
            rstN = r; keyN = k; jtag = j; bsel = b; kick = w;
            @(posedge clk);
            modelStep();
            @(negedge clk);
            checkOutput("model");
        end
    endtask

    initial begin
        //                rN k  j  b  cyc core fetch addr cnt
        vecs[0]  = mk(0, 1, 0, 0,  3, 0, 0, BA0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 15, 0, 0, BA0, 0);
        vecs[2]  = mk(1, 1, 0, 0,  1, 1, 0, BA0, 0);
        vecs[3]  = mk(1, 1, 0, 0,  7, 1, 0, BA0, 0);
        vecs[4]  = mk(1, 1, 0, 0,  1, 1, 1, BA0, 1);
        vecs[5]  = mk(1, 1, 1, 1,  3, 0, 0, BA0, 1);
        vecs[6]  = mk(1, 1, 0, 1, 15, 0, 0, BA0, 1);
        vecs[7]  = mk(1, 1, 0, 1,  1, 1, 0, BA1, 1);
        vecs[8]  = mk(1, 1, 0, 0,  8, 1, 1, BA1, 2);
        vecs[9]  = mk(1, 1, 0, 0, 10, 1, 1, BA1, 2);
        vecs[10] = mk(1, 1, 1, 0,  1, 0, 0, BA1, 2);
        vecs[11] = mk(1, 1, 0, 0, 16, 1, 0, BA0, 2);
        vecs[12] = mk(1, 1, 0, 0,  3, 1, 0, BA0, 2);
        vecs[13] = mk(1, 1, 1, 0,  3, 0, 0, BA0, 2);
        vecs[14] = mk(1, 1, 0, 0, 15, 0, 0, BA0, 2);
        vecs[15] = mk(1, 1, 0, 0,  1, 1, 0, BA0, 2);
        vecs[16] = mk(1, 1, 0, 0,  8, 1, 1, BA0, 3);
        vecs[17] = mk(1, 0, 0, 0, 19, 1, 1, BA0, 3);
        vecs[18] = mk(1, 1, 0, 0,  3, 1, 1, BA0, 3);
        vecs[19] = mk(1, 0, 0, 0, 22, 1, 1, BA0, 3);
        vecs[20] = mk(1, 0, 0, 0,  1, 0, 0, BA0, 3);
        vecs[21] = mk(1, 1, 0, 0, 37, 0, 0, BA0, 3);
        vecs[22] = mk(1, 1, 0, 0,  1, 1, 0, BA0, 3);
        vecs[23] = mk(1, 1, 0, 0,  4, 1, 0, BA0, 3);
        vecs[24] = mk(0, 1, 0, 0,  1, 0, 0, BA0, 0);
        vecs[25] = mk(1, 1, 0, 0, 15, 0, 0, BA0, 0);
        vecs[26] = mk(1, 1, 0, 0,  1, 1, 0, BA0, 0);
        vecs[27] = mk(1, 1, 0, 0,  8, 1, 1, BA0, 1);

        $display("[TB] directed vector table");
        for (int v = 0; v < 28; v++) begin
            applyStimulus(vecs[v].rN, vecs[v].k, vecs[v].j, vecs[v].b, 1'b0, vecs[v].cycles);
            expectOut($sformatf("vec%0d", v), vecs[v].eCore, vecs[v].eFetch,
                      vecs[v].eAddr, vecs[v].eCnt, 1'b0);
        end

        $display("[TB] randomized segments");
        for (int s = 0; s < 120; s++) begin
            bit k, b;
            int len;
            len = $urandom_range(1, 40);
            k   = ($urandom_range(0, 2) != 0);
            b   = $urandom_range(0, 1);
            for (int c = 0; c < len; c++) begin
                applyStimulus(($urandom_range(0, 799) != 0), k,
                              ($urandom_range(0, 149) == 0), b,
                              ($urandom_range(0, 89) == 0), 1);
            end
        end

`ifdef BOOT_CTRL_WATCHDOG_EN
        $display("[TB] watchdog sequence");
        applyStimulus(0, 1, 0, 0, 0, 2);
        applyStimulus(1, 1, 0, 0, 0, HOLD + FETCH);
        expectOut("wdt_run", 1, 1, BA0, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, WDT - 1);
        expectOut("wdt_not_early", 1, 1, BA0, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 1);
        expectOut("wdt_expire", 0, 0, BA0, 1, 1);
        applyStimulus(1, 1, 0, 0, 0, HOLD + FETCH);
        expectOut("wdt_rerun", 1, 1, BA0, 2, 1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, 0, 0, 0, 49);
            applyStimulus(1, 1, 0, 0, 1, 1);
        end
        expectOut("wdt_kicked", 1, 1, BA0, 2, 1);
`else
        $display("[TB] watchdog absent sequence");
        applyStimulus(0, 1, 0, 0, 0, 2);
        applyStimulus(1, 1, 0, 0, 0, HOLD + FETCH);
        expectOut("nowdt_run", 1, 1, BA0, 1, 0);
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1, 1, 0, 0, ($urandom_range(0, 3) == 0), 1);
        end
        expectOut("nowdt_idle", 1, 1, BA0, 1, 0);
`endif

        $display("[TB] reset counter saturation");
        applyStimulus(0, 1, 0, 0, 0, 2);
        applyStimulus(1, 1, 0, 0, 0, HOLD + FETCH);
        expectOut("sat_first", 1, 1, BA0, 1, 0);
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1, 1, 1, 0, 0, 1);
            applyStimulus(1, 1, 0, 0, 0, HOLD + FETCH);
        end
        expectOut("sat_255", 1, 1, BA0, 255, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pulpino_boot_ctrl.md
PULPINO_BOOT_CTRL -- requirements
Module: pulpino_boot_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 16, is the number of cycles core reset is held after the last reset request clears (range 1..65535).
REQ-002 Parameter FETCH_DELAY, default 8, is the number of cycles between core reset release and fetch_enable assertion (range 1..65535).
REQ-003 Parameter DEBOUNCE_CYCLES, default 50000, is the number of consecutive stable cycles required to accept a key level change.
REQ-004 Parameters BOOT_ADDR_0 (default 32'h00008000) and BOOT_ADDR_1 (default 32'h00000000) are the two selectable boot addresses.
REQ-005 Parameter WDT_CYCLES, default 50000000, is the watchdog timeout in cycles.
REQ-006 clk_clk  input  1  system clock; all logic is on its rising edge.
REQ-007 reset_reset_n  input  1  synchronous, active-low block reset.
REQ-008 key_n  input  1  raw asynchronous push-button, low = pressed.
REQ-009 jtag_reset  input  1  reset request from the debug master, high = request.
REQ-010 boot_sel  input  1  asynchronous boot-address select switch.
REQ-011 wdt_kick  input  1  single-cycle watchdog refresh pulse from core GPIO.
REQ-012 core_reset_n  output  1  core reset, low = held in reset.
REQ-013 fetch_enable  output  1  core instruction fetch enable.
REQ-014 boot_addr  output  32  latched core boot address.
REQ-015 reset_count  output  8  number of completed core reset sequences.
REQ-016 wdt_fired  output  1  sticky flag set by a watchdog-caused reset.

Function
REQ-017 key_n and boot_sel SHALL each pass through a 2-flop synchronizer before use.
REQ-018 The debounced key level SHALL change only after the synchronized key_n holds the new level for DEBOUNCE_CYCLES consecutive cycles; any mismatch SHALL restart the count.
REQ-019 Reset request (req) = debounced key low OR jtag_reset OR watchdog expiry pulse.
REQ-020 FSM states: HOLD (core_reset_n=0, fetch_enable=0), RELEASE (core_reset_n=1, fetch_enable=0), RUN (core_reset_n=1, fetch_enable=1).
REQ-021 In HOLD the cycle counter SHALL stay 0 while req=1 and increment while req=0; at HOLD_CYCLES it SHALL go to RELEASE, clear the counter and latch boot_addr from the synchronized boot_sel (0 -> BOOT_ADDR_0, 1 -> BOOT_ADDR_1).
REQ-022 In RELEASE, after FETCH_DELAY cycles the FSM SHALL go to RUN and increment reset_count, saturating at 255.
REQ-023 req=1 in RELEASE or RUN SHALL move the FSM to HOLD on the next edge with the counter cleared; outputs are registered, so they change one cycle after the req edge.
REQ-024 boot_addr SHALL change only at the HOLD->RELEASE transition; boot_sel changes at any other time SHALL be ignored.

Reset
REQ-025 With reset_reset_n=0 at a clock edge: FSM=HOLD, counters=0, core_reset_n=0, fetch_enable=0, boot_addr=BOOT_ADDR_0, reset_count=0, wdt_fired=0, debounced key=released, synchronizers=released/0.
REQ-026 Block reset asserted mid-sequence SHALL abort the sequence immediately; the full HOLD/RELEASE timing SHALL restart after deassertion.

Configuration
REQ-027 Macro BOOT_CTRL_WATCHDOG_EN defined: a watchdog counter runs only in RUN, clears on wdt_kick or on leaving RUN, and on reaching WDT_CYCLES emits one expiry pulse (req) and sets wdt_fired; wdt_fired clears only on block reset.
REQ-028 Macro undefined: no watchdog logic, wdt_kick ignored, wdt_fired tied 0.

Verification
REQ-029 Block reset release, HOLD_CYCLES=16, FETCH_DELAY=8 -> core_reset_n rises 16 cycles later, fetch_enable 8 cycles after that, reset_count=1.
REQ-030 key_n glitches low for DEBOUNCE_CYCLES-1 cycles in RUN -> no state change; held low DEBOUNCE_CYCLES cycles -> HOLD, fetch_enable=0 and core_reset_n=0.
REQ-031 jtag_reset pulsed 3 cycles during RELEASE -> HOLD, counter restarts after pulse ends, RUN reached after full 16+8 cycles.
REQ-032 boot_sel=1 during HOLD then toggled to 0 in RUN -> boot_addr=32'h00000000 and unchanged in RUN.
REQ-033 BOOT_CTRL_WATCHDOG_EN, WDT_CYCLES=100, no kicks in RUN -> reset at cycle 100, wdt_fired=1; kicks every 50 cycles -> no reset.
REQ-034 256 jtag resets -> reset_count saturates at 255.
